// File: rtl/game_pkg.sv
// game_pkg: shared tile/mode/heading types, map geometry and movement helpers
package game_pkg;
    localparam int MAP_WIDTH  = 80;
    localparam int MAP_HEIGHT = 60;
    localparam logic [7:0] start_x_1 = 8'd20;
    localparam logic [7:0] start_y_1 = 8'd30;
    localparam logic [7:0] start_x_2 = 8'd60;
    localparam logic [7:0] start_y_2 = 8'd30;
    typedef enum logic [1:0] {EMPTY, FRAME, PLAYER1, PLAYER2} tile;
    typedef enum logic [2:0] {MENU, PLAY, PLAYER1_WIN, PLAYER2_WIN, DRAW} game_mode;
    typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} direction_t;
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOOK1, S_LOOK2, S_COMMIT1, S_COMMIT2} motion_state_t;
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } pos_t;
    function automatic direction_t opposite(input direction_t d);
        return direction_t'(d ^ 2'b10);
    endfunction
    function automatic direction_t steer(input direction_t cur, input direction_t req);
        return req == opposite(cur) ? cur : req;
    endfunction
    function automatic pos_t step_pos(input pos_t p, input direction_t d);
        pos_t n;
        n.x = d == RIGHT ? p.x + 8'd1 : d == LEFT ? p.x - 8'd1 : p.x;
        n.y = d == DOWN ? p.y + 8'd1 : d == UP ? p.y - 8'd1 : p.y;
        return n;
    endfunction
endpackage

// File: rtl/player_motion_step_timer.sv
// step_timer: free-running 0..MOVE_DIV-1 counter while enabled, one-cycle tick at the top
module step_timer #(
    parameter int MOVE_DIV = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(MOVE_DIV);
    logic [W-1:0] cnt_q;
    assign tick = en && cnt_q == W'(MOVE_DIV - 1);
    // count while enabled, wrap on tick, hold at zero otherwise
    always_ff @(posedge clk) begin
        if (rst || !en || tick) cnt_q <= '0;
        else cnt_q <= cnt_q + W'(1);
    end
endmodule

// File: rtl/player_motion.sv
// player_motion: head positions, headings, collision checks and game mode for both players
module player_motion
    import game_pkg::*;
#(
    parameter int MOVE_DIV = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] dir_1,
    input  logic [1:0] dir_2,
    input  tile        tile_in,
    output logic [7:0] tile_x,
    output logic [7:0] tile_y,
    output logic [7:0] current_x_1,
    output logic [7:0] current_y_1,
    output logic [7:0] current_x_2,
    output logic [7:0] current_y_2,
    output logic [1:0] selected_player,
    output game_mode   mode
);
    localparam pos_t START_1 = '{x: start_x_1, y: start_y_1};
    localparam pos_t START_2 = '{x: start_x_2, y: start_y_2};
    motion_state_t state_q, state_d;
    game_mode mode_q, mode_d;
    pos_t head1_q, head1_d, head2_q, head2_d;
    pos_t nxt1_q, nxt1_d, nxt2_q, nxt2_d;
    pos_t look_q, look_d;
    direction_t hd1_q, hd1_d, hd2_q, hd2_d;
    direction_t h1_new, h2_new;
    pos_t n1, n2;
    logic crash1_q, crash1_d, crash2, head_on, tick;
    logic [1:0] sel_q, sel_d;
    step_timer #(.MOVE_DIV(MOVE_DIV)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (mode_q == PLAY),
        .tick (tick)
    );
    // next-state and registered-output logic of the step sequencer
    always_comb begin
        h1_new   = steer(hd1_q, direction_t'(dir_1));
        h2_new   = steer(hd2_q, direction_t'(dir_2));
        n1       = step_pos(head1_q, h1_new);
        n2       = step_pos(head2_q, h2_new);
        crash2   = tile_in != EMPTY;
        head_on  = nxt1_q == nxt2_q;
        state_d  = state_q;
        mode_d   = mode_q;
        head1_d  = head1_q;
        head2_d  = head2_q;
        nxt1_d   = nxt1_q;
        nxt2_d   = nxt2_q;
        look_d   = look_q;
        hd1_d    = hd1_q;
        hd2_d    = hd2_q;
        crash1_d = crash1_q;
        sel_d    = 2'b00;
        case (state_q)
            S_IDLE: if (start) begin
                mode_d  = PLAY;
                head1_d = START_1;
                head2_d = START_2;
                hd1_d   = RIGHT;
                hd2_d   = LEFT;
                state_d = S_WAIT;
            end
            S_WAIT: if (tick) begin
                hd1_d   = h1_new;
                hd2_d   = h2_new;
                nxt1_d  = n1;
                nxt2_d  = n2;
                look_d  = n1;
                state_d = S_LOOK1;
            end
            S_LOOK1: begin
                crash1_d = tile_in != EMPTY;
                look_d   = nxt2_q;
                state_d  = S_LOOK2;
            end
            S_LOOK2: begin
                state_d = S_IDLE;
                if (head_on || (crash1_q && crash2)) mode_d = DRAW;
                else if (crash1_q) mode_d = PLAYER2_WIN;
                else if (crash2) mode_d = PLAYER1_WIN;
                else begin
                    head1_d = nxt1_q;
                    head2_d = nxt2_q;
                    sel_d   = 2'b01;
                    state_d = S_COMMIT1;
                end
            end
            S_COMMIT1: begin
                sel_d   = 2'b11;
                state_d = S_COMMIT2;
            end
            S_COMMIT2: state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end
    // state and datapath registers with synchronous reset to the round-start values
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= MENU;
            head1_q  <= START_1;
            head2_q  <= START_2;
            nxt1_q   <= '0;
            nxt2_q   <= '0;
            look_q   <= '0;
            hd1_q    <= RIGHT;
            hd2_q    <= LEFT;
            crash1_q <= 1'b0;
            sel_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            head1_q  <= head1_d;
            head2_q  <= head2_d;
            nxt1_q   <= nxt1_d;
            nxt2_q   <= nxt2_d;
            look_q   <= look_d;
            hd1_q    <= hd1_d;
            hd2_q    <= hd2_d;
            crash1_q <= crash1_d;
            sel_q    <= sel_d;
        end
    end
    assign tile_x          = look_q.x;
    assign tile_y          = look_q.y;
    assign current_x_1     = head1_q.x;
    assign current_y_1     = head1_q.y;
    assign current_x_2     = head2_q.x;
    assign current_y_2     = head2_q.y;
    assign selected_player = sel_q;
    assign mode            = mode_q;
endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: directed scoreboard bench for player_motion with a one-tile map model
module tb_player_motion;
    import game_pkg::*;
    logic clk = 1'b0;
    logic rst, start;
    logic [1:0] dir_1, dir_2;
    tile tile_in;
    logic [7:0] tile_x, tile_y, current_x_1, current_y_1, current_x_2, current_y_2;
    logic [1:0] selected_player;
    game_mode mode;
    logic bad_en;
    logic [7:0] bad_x, bad_y;
    int cyc = 0;
    int last_commit = 0;
    int vectors = 0;
    int miscompares = 0;
    int quiet;
    typedef struct {
        logic [7:0] x1, y1, x2, y2;
    } exp_t;
    exp_t q[$];

    player_motion #(.MOVE_DIV(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .dir_1           (dir_1),
        .dir_2           (dir_2),
        .tile_in         (tile_in),
        .tile_x          (tile_x),
        .tile_y          (tile_y),
        .current_x_1     (current_x_1),
        .current_y_1     (current_y_1),
        .current_x_2     (current_x_2),
        .current_y_2     (current_y_2),
        .selected_player (selected_player),
        .mode            (mode)
    );

    assign tile_in = (bad_en && tile_x == bad_x && tile_y == bad_y) ? FRAME : EMPTY;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int x1, input int y1, input int x2, input int y2);
        exp_t e;
        e.x1 = 8'(x1);
        e.y1 = 8'(y1);
        e.x2 = 8'(x2);
        e.y2 = 8'(y2);
        q.push_back(e);
    endtask

    task automatic check_heads(input string tag, input int x1, input int y1, input int x2, input int y2);
        check({tag, "_x1"}, current_x_1, x1);
        check({tag, "_y1"}, current_y_1, y1);
        check({tag, "_x2"}, current_x_2, x2);
        check({tag, "_y2"}, current_y_2, y2);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic commit_c1(input string tag, input int gap);
        int n = 0;
        exp_t e;
        do begin
            @(negedge clk);
            n++;
        end while (selected_player !== 2'b01 && n < 40);
        check({tag, "_seen"}, 32'(n < 40), 1);
        check({tag, "_gap"}, cyc - last_commit, gap);
        last_commit = cyc;
        check({tag, "_sb"}, 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check_heads(tag, e.x1, e.y1, e.x2, e.y2);
        end
    endtask

    task automatic commit(input string tag, input int gap);
        commit_c1(tag, gap);
        @(negedge clk);
        check({tag, "_sel2"}, selected_player, 2'b11);
        @(negedge clk);
        check({tag, "_sel0"}, selected_player, 2'b00);
    endtask

    task automatic wait_end(input string tag, input game_mode m, input int x1, input int y1, input int x2, input int y2);
        int n = 0;
        int writes = 0;
        do begin
            @(negedge clk);
            n++;
            if (selected_player !== 2'b00) writes++;
        end while (mode === PLAY && n < 40);
        check({tag, "_seen"}, 32'(n < 40), 1);
        check({tag, "_mode"}, mode, m);
        check({tag, "_gap"}, cyc - last_commit, 8);
        check_heads(tag, x1, y1, x2, y2);
        repeat (6) begin
            @(negedge clk);
            if (selected_player !== 2'b00 || mode !== m || current_x_1 !== 8'(x1) || current_x_2 !== 8'(x2)) writes++;
        end
        check({tag, "_frozen"}, writes, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dir_1 = 2'b01;
        dir_2 = 2'b11;
        bad_en = 1'b0;
        bad_x = 8'd0;
        bad_y = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mode", mode, MENU);
        check("rst_sel", selected_player, 2'b00);
        check("rst_tx", tile_x, 0);
        check("rst_ty", tile_y, 0);
        check_heads("rst", start_x_1, start_y_1, start_x_2, start_y_2);
        rst = 1'b0;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (selected_player !== 2'b00 || mode !== MENU || current_x_1 !== start_x_1 || current_x_2 !== start_x_2) quiet++;
        end
        check("idle_quiet", quiet, 0);

        push(21, 30, 59, 30);
        push(22, 30, 58, 30);
        push(23, 30, 57, 30);
        push(23, 29, 56, 30);
        pulse_start();
        check("play_mode", mode, PLAY);
        last_commit = cyc;
        commit("s1", 10);
        commit("s2", 8);
        dir_1 = 2'b11;
        pulse_start();
        commit("s3_reverse_ignored", 8);
        dir_1 = 2'b00;
        commit("s4_turn_up", 8);

        bad_x = 8'd23;
        bad_y = 8'd28;
        bad_en = 1'b1;
        wait_end("p1_crash", PLAYER2_WIN, 23, 29, 56, 30);
        bad_en = 1'b0;

        dir_1 = 2'b11;
        dir_2 = 2'b11;
        for (int k = 1; k <= 19; k++) push(20 + k, 30, 60 - k, 30);
        pulse_start();
        check("restart_mode", mode, PLAY);
        check_heads("restart", start_x_1, start_y_1, start_x_2, start_y_2);
        last_commit = cyc;
        for (int k = 1; k <= 19; k++) commit($sformatf("d%0d", k), k == 1 ? 10 : 8);
        wait_end("head_on", DRAW, 39, 30, 41, 30);

        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_over_start", mode, MENU);
        @(negedge clk);
        check("rst_over_start_hold", mode, MENU);

        dir_1 = 2'b01;
        dir_2 = 2'b11;
        push(21, 30, 59, 30);
        pulse_start();
        last_commit = cyc;
        commit_c1("r1", 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_c1_sel", selected_player, 2'b00);
        check("rst_c1_mode", mode, MENU);
        check("rst_c1_tx", tile_x, 0);
        check_heads("rst_c1", start_x_1, start_y_1, start_x_2, start_y_2);
        quiet = 0;
        repeat (12) begin
            @(negedge clk);
            if (selected_player !== 2'b00 || mode !== MENU) quiet++;
        end
        check("rst_c1_quiet", quiet, 0);
        check("sb_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
